alu_issue: RTL and testbench

Registered ID/EX issue stage that drives the single-cycle ALU. Decodes a MIPS instruction word plus its two register-file read values into the ALU control word (`ALUFun`, `Sign`), the operands (`inA`, `inB`) and the write-back destination. Holds them in a valid/ready pipeline register with stall and flush, and counts issued operations. It sits between register read and the ALU; its outputs wire directly to the ALU inputs.

---
 rtl/alu_issue.sv | 191 +++++++++++++++++++
 tb/tb_alu_issue.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// alu_issue: registered ID/EX issue stage feeding the single-cycle ALU.
// Decodes a MIPS word plus register read values into ALU control, operands
// and write-back destination, held in a valid/ready register with stall and
// flush, and counts completed output handshakes.
module alu_issue (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [5:0]  ALUFun,
  output logic        Sign,
  output logic [31:0] inA,
  output logic [31:0] inB,
  output logic [4:0]  dest,
  output logic        wr_en,
  output logic        illegal,
  output logic [31:0] issue_count
);

  localparam logic [5:0] FUN_ADD = 6'b000000;
  localparam logic [5:0] FUN_SUB = 6'b000001;
  localparam logic [5:0] FUN_AND = 6'b011000;
  localparam logic [5:0] FUN_OR  = 6'b011110;
  localparam logic [5:0] FUN_XOR = 6'b010110;
  localparam logic [5:0] FUN_NOR = 6'b010001;
  localparam logic [5:0] FUN_SLL = 6'b100000;
  localparam logic [5:0] FUN_SRL = 6'b100001;
  localparam logic [5:0] FUN_SRA = 6'b100011;
  localparam logic [5:0] FUN_EQ  = 6'b110010;
  localparam logic [5:0] FUN_NEQ = 6'b110000;
  localparam logic [5:0] FUN_LT  = 6'b110100;
  localparam logic [5:0] FUN_LEZ = 6'b111100;
  localparam logic [5:0] FUN_GTZ = 6'b111110;

  logic [5:0]  op, funct;
  logic [4:0]  shamt, rt, rd;
  logic [15:0] imm;
  logic [31:0] imm_se, imm_ze, shamt_ze;

  logic [5:0]  d_fun;
  logic        d_sign, d_wr, d_ill;
  logic [31:0] d_a, d_b;
  logic [4:0]  d_dest;

  logic load, consume;

  // The rs index field is not needed: rs_data arrives already read.
  logic unused_rs;
  assign unused_rs = ^instr[25:21];

  assign op       = instr[31:26];
  assign funct    = instr[5:0];
  assign shamt    = instr[10:6];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign imm      = instr[15:0];
  assign imm_se   = {{16{imm[15]}}, imm};
  assign imm_ze   = {16'b0, imm};
  assign shamt_ze = {27'b0, shamt};

  // Flush blocks input that cycle; otherwise accept whenever the slot frees up.
  assign in_ready = ~flush & (~out_valid | out_ready);
  assign load     = in_valid & in_ready;
  assign consume  = out_valid & out_ready;

  // Combinational decode; anything unrecognised falls out as an illegal bubble.
  always_comb begin
    d_fun  = FUN_ADD;
    d_sign = 1'b0;
    d_a    = 32'b0;
    d_b    = 32'b0;
    d_dest = 5'b0;
    d_wr   = 1'b0;
    d_ill  = 1'b1;
    case (op)
      6'h00: begin
        d_dest = rd;
        d_wr   = 1'b1;
        d_a    = rs_data;
        d_b    = rt_data;
        d_ill  = 1'b0;
        case (funct)
          6'h20: d_sign = 1'b1;
          6'h21: d_sign = 1'b0;
          6'h22: begin d_fun = FUN_SUB; d_sign = 1'b1; end
          6'h23: d_fun = FUN_SUB;
          6'h24: d_fun = FUN_AND;
          6'h25: d_fun = FUN_OR;
          6'h26: d_fun = FUN_XOR;
          6'h27: d_fun = FUN_NOR;
          6'h2A: begin d_fun = FUN_LT; d_sign = 1'b1; end
          6'h2B: d_fun = FUN_LT;
          6'h00: begin d_fun = FUN_SLL; d_a = shamt_ze; end
          6'h02: begin d_fun = FUN_SRL; d_a = shamt_ze; end
          6'h03: begin d_fun = FUN_SRA; d_a = shamt_ze; end
          6'h04: d_fun = FUN_SLL;
          6'h06: d_fun = FUN_SRL;
          6'h07: d_fun = FUN_SRA;
          default: begin
            d_dest = 5'b0;
            d_wr   = 1'b0;
            d_a    = 32'b0;
            d_b    = 32'b0;
            d_ill  = 1'b1;
          end
        endcase
      end
      6'h08, 6'h09, 6'h0A, 6'h0B: begin
        d_dest = rt;
        d_wr   = 1'b1;
        d_a    = rs_data;
        d_b    = imm_se;
        d_ill  = 1'b0;
        d_fun  = op[1] ? FUN_LT : FUN_ADD;
        d_sign = ~op[0];
      end
      6'h0C, 6'h0D, 6'h0E: begin
        d_dest = rt;
        d_wr   = 1'b1;
        d_a    = rs_data;
        d_b    = imm_ze;
        d_ill  = 1'b0;
        d_fun  = (op == 6'h0C) ? FUN_AND : (op == 6'h0D) ? FUN_OR : FUN_XOR;
      end
      6'h0F: begin
        // LUI is a left shift of the zero-extended immediate by 16.
        d_dest = rt;
        d_wr   = 1'b1;
        d_a    = 32'd16;
        d_b    = imm_ze;
        d_ill  = 1'b0;
        d_fun  = FUN_SLL;
      end
      6'h04, 6'h05, 6'h06, 6'h07: begin
        d_sign = 1'b1;
        d_a    = rs_data;
        d_ill  = 1'b0;
        case (op[1:0])
          2'd0:    begin d_fun = FUN_EQ;  d_b = rt_data; end
          2'd1:    begin d_fun = FUN_NEQ; d_b = rt_data; end
          2'd2:    d_fun = FUN_LEZ;
          default: d_fun = FUN_GTZ;
        endcase
      end
      default: ;
    endcase
  end

  // Pipeline register: reset clears payload, flush only invalidates.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      ALUFun    <= 6'b0;
      Sign      <= 1'b0;
      inA       <= 32'b0;
      inB       <= 32'b0;
      dest      <= 5'b0;
      wr_en     <= 1'b0;
      illegal   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      ALUFun    <= d_fun;
      Sign      <= d_sign;
      inA       <= d_a;
      inB       <= d_b;
      dest      <= d_dest;
      wr_en     <= d_wr;
      illegal   <= d_ill;
    end else if (consume) begin
      out_valid <= 1'b0;
    end
  end

  // Count output handshakes, including one that completes during a flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      issue_count <= 32'b0;
    end else if (consume) begin
      issue_count <= issue_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: scoreboard bench for alu_issue. Expected decodes are pushed
// on input handshake and compared while the entry is held in the stage.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] instr, rs_data, rt_data, inA, inB, issue_count;
  logic [5:0]  ALUFun;
  logic        Sign, wr_en, illegal;
  logic [4:0]  dest;

  alu_issue dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs_data(rs_data), .rt_data(rt_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .ALUFun(ALUFun), .Sign(Sign),
    .inA(inA), .inB(inB), .dest(dest), .wr_en(wr_en), .illegal(illegal),
    .issue_count(issue_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  fun;
    logic        sign;
    logic        chk_sign;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  dst;
    logic        wr;
    logic        ill;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_cnt = 32'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] rs, input logic [31:0] rt);
    exp_t e;
    logic [31:0] se, ze;
    se = {{16{w[15]}}, w[15:0]};
    ze = {16'h0, w[15:0]};
    e = '{fun: 6'b000000, sign: 1'b0, chk_sign: 1'b1, a: 32'h0, b: 32'h0,
          dst: 5'd0, wr: 1'b0, ill: 1'b1};
    if (w[31:26] == 6'h00) begin
      e.ill = 1'b0; e.wr = 1'b1; e.dst = w[15:11]; e.a = rs; e.b = rt;
      case (w[5:0])
        6'h20: e.sign = 1'b1;
        6'h21: e.sign = 1'b0;
        6'h22: begin e.fun = 6'b000001; e.sign = 1'b1; end
        6'h23: e.fun = 6'b000001;
        6'h24: e.fun = 6'b011000;
        6'h25: e.fun = 6'b011110;
        6'h26: e.fun = 6'b010110;
        6'h27: e.fun = 6'b010001;
        6'h2A: begin e.fun = 6'b110100; e.sign = 1'b1; end
        6'h2B: e.fun = 6'b110100;
        6'h00: begin e.fun = 6'b100000; e.a = {27'h0, w[10:6]}; e.chk_sign = 1'b0; end
        6'h02: begin e.fun = 6'b100001; e.a = {27'h0, w[10:6]}; e.chk_sign = 1'b0; end
        6'h03: begin e.fun = 6'b100011; e.a = {27'h0, w[10:6]}; e.chk_sign = 1'b0; end
        6'h04: begin e.fun = 6'b100000; e.chk_sign = 1'b0; end
        6'h06: begin e.fun = 6'b100001; e.chk_sign = 1'b0; end
        6'h07: begin e.fun = 6'b100011; e.chk_sign = 1'b0; end
        default: begin e.ill = 1'b1; e.wr = 1'b0; e.dst = 5'd0; e.a = 32'h0; e.b = 32'h0; end
      endcase
    end else begin
      case (w[31:26])
        6'h08: e = '{6'b000000, 1'b1, 1'b1, rs, se, w[20:16], 1'b1, 1'b0};
        6'h09: e = '{6'b000000, 1'b0, 1'b1, rs, se, w[20:16], 1'b1, 1'b0};
        6'h0A: e = '{6'b110100, 1'b1, 1'b1, rs, se, w[20:16], 1'b1, 1'b0};
        6'h0B: e = '{6'b110100, 1'b0, 1'b1, rs, se, w[20:16], 1'b1, 1'b0};
        6'h0C: e = '{6'b011000, 1'b0, 1'b0, rs, ze, w[20:16], 1'b1, 1'b0};
        6'h0D: e = '{6'b011110, 1'b0, 1'b0, rs, ze, w[20:16], 1'b1, 1'b0};
        6'h0E: e = '{6'b010110, 1'b0, 1'b0, rs, ze, w[20:16], 1'b1, 1'b0};
        6'h0F: e = '{6'b100000, 1'b0, 1'b0, 32'd16, ze, w[20:16], 1'b1, 1'b0};
        6'h04: e = '{6'b110010, 1'b1, 1'b1, rs, rt, 5'd0, 1'b0, 1'b0};
        6'h05: e = '{6'b110000, 1'b1, 1'b1, rs, rt, 5'd0, 1'b0, 1'b0};
        6'h06: e = '{6'b111100, 1'b1, 1'b1, rs, 32'h0, 5'd0, 1'b0, 1'b0};
        6'h07: e = '{6'b111110, 1'b1, 1'b1, rs, 32'h0, 5'd0, 1'b0, 1'b0};
        default: ;
      endcase
    end
    return e;
  endfunction

  // One cycle: inputs already driven after a negedge; check, update model, advance.
  task automatic tick();
    exp_t e;
    logic exp_ov, exp_ir;
    #2;
    if (!reset) begin
      exp_ov = (q.size() != 0);
      exp_ir = !flush && (!exp_ov || out_ready);
      check("out_valid", 32'(out_valid), 32'(exp_ov));
      check("in_ready", 32'(in_ready), 32'(exp_ir));
      check("issue_count", issue_count, exp_cnt);
      if (exp_ov) begin
        e = q[0];
        check("alufun", 32'(ALUFun), 32'(e.fun));
        if (e.chk_sign) check("sign", 32'(Sign), 32'(e.sign));
        check("inA", inA, e.a);
        check("inB", inB, e.b);
        check("dest", 32'(dest), 32'(e.dst));
        check("wr_en", 32'(wr_en), 32'(e.wr));
        check("illegal", 32'(illegal), 32'(e.ill));
        if (out_ready) begin
          void'(q.pop_front());
          exp_cnt = exp_cnt + 32'd1;
        end else if (flush) begin
          void'(q.pop_front());
        end
      end
      if (in_valid && exp_ir) q.push_back(ref_decode(instr, rs_data, rt_data));
    end
    @(posedge clk);
    if (reset) begin
      q.delete();
      exp_cnt = 32'd0;
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic [31:0] w, input logic [31:0] rs, input logic [31:0] rt,
                       input logic iv, input logic ordy, input logic fl);
    instr = w; rs_data = rs; rt_data = rt;
    in_valid = iv; out_ready = ordy; flush = fl;
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ov"}, 32'(out_valid), 32'd0);
    check({tag, "_fun"}, 32'(ALUFun), 32'd0);
    check({tag, "_sign"}, 32'(Sign), 32'd0);
    check({tag, "_inA"}, inA, 32'd0);
    check({tag, "_inB"}, inB, 32'd0);
    check({tag, "_dest"}, 32'(dest), 32'd0);
    check({tag, "_wr"}, 32'(wr_en), 32'd0);
    check({tag, "_ill"}, 32'(illegal), 32'd0);
    check({tag, "_cnt"}, issue_count, 32'd0);
  endtask

  logic [31:0] pool [16] = '{
    32'h00221820, 32'h00221822, 32'h00221825, 32'h00221827, 32'h0022182A,
    32'h0022182B, 32'h00221986, 32'h000628C2, 32'h2022FFFC, 32'h2C228001,
    32'h3422ABCD, 32'h3C041234, 32'h10220005, 32'h14220005, 32'h1C200003,
    32'hFC000000};

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    instr = 32'h0; rs_data = 32'h0; rt_data = 32'h0;
    @(negedge clk);
    tick(); tick();
    check_all_zero("rst");
    reset = 1'b0;

    // add, then consume
    drive(32'h00221820, 32'd5, 32'd7, 1'b1, 1'b1, 1'b0);
    drive(32'h0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    check("add_count", issue_count, 32'd1);

    // addi / lui back to back
    drive(32'h2022FFFC, 32'd1, 32'd0, 1'b1, 1'b1, 1'b0);
    drive(32'h3C041234, 32'd1, 32'd0, 1'b1, 1'b1, 1'b0);
    drive(32'h0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);

    // sra, stall 3 cycles with a pending add, then release with no bubble
    drive(32'h000628C3, 32'd0, 32'h80000000, 1'b1, 1'b0, 1'b0);
    repeat (3) drive(32'h00221820, 32'd9, 32'd4, 1'b1, 1'b0, 1'b0);
    drive(32'h00221820, 32'd9, 32'd4, 1'b1, 1'b1, 1'b0);
    drive(32'h0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);

    // beq with equal operands, then an illegal opcode
    drive(32'h10220005, 32'd42, 32'd42, 1'b1, 1'b1, 1'b0);
    drive(32'hFC000000, 32'd3, 32'd4, 1'b1, 1'b1, 1'b0);
    drive(32'h0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);

    // flush while stalled with input offered
    drive(32'h00221826, 32'd6, 32'd3, 1'b1, 1'b0, 1'b0);
    drive(32'h00221820, 32'd1, 32'd1, 1'b1, 1'b0, 1'b1);
    drive(32'h0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);

    // mixed traffic
    for (int i = 0; i < 40; i++) begin
      drive(pool[$urandom_range(0, 15)], $urandom, $urandom,
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 7) == 0));
    end
    drive(32'h0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);

    // counter wrap: preload the counter just before a handshake
    drive(32'h00221821, 32'd2, 32'd3, 1'b1, 1'b0, 1'b0);
    dut.issue_count = 32'hFFFFFFFF;
    exp_cnt = 32'hFFFFFFFF;
    drive(32'h0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    check("wrap", issue_count, 32'd0);

    // reset while stalled
    drive(32'h0022182A, 32'hFFFFFFFF, 32'd1, 1'b1, 1'b0, 1'b0);
    drive(32'h0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    in_valid = 1'b0;
    check_all_zero("midrst");
    drive(32'h0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
